// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the pipe_MIPS32 byte-serial program loader.
package mips_loader_pkg;

    localparam logic [7:0]  LOADER_SYNC_BYTE = 8'hA5;
    localparam int unsigned BYTES_PER_WORD   = 4;
    localparam int unsigned BYTE_CNT_W       = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StData,
        StChk,
        StStart,
        StError
    } loader_state_e;

    // A frame may carry between 1 and 2**addr_w words.
    function automatic logic count_valid(input logic [15:0] n, input int unsigned addr_w);
        return (n != 16'd0) && ({16'd0, n} <= (32'd1 << addr_w));
    endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian byte-to-word assembler; flags the strobe that completes each 32-bit word.
module loader_word_asm
    import mips_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_strobe,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_done
);

    logic [23:0]           r_shift;
    logic [BYTE_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (i_strobe) begin
            r_shift <= {r_shift[15:0], i_byte};
            r_cnt   <= r_cnt + BYTE_CNT_W'(1);
        end
    end

    // The completing byte is merged combinationally so the parent can register the word.
    assign o_word      = {r_shift, i_byte};
    assign o_word_done = i_strobe && (r_cnt == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mips_prog_loader.sv
// Framed boot loader: writes a program image into instruction memory, then starts the core.
// Optional CHK byte verification is enabled by defining LOADER_CHECKSUM_EN.
module mips_prog_loader
    import mips_loader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 32,
    parameter logic [7:0]  SYNC_BYTE = LOADER_SYNC_BYTE
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              core_halt,
    output logic              core_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_e     r_state;
    loader_state_e     w_state_next;
    logic [7:0]        r_cnt_hi;
    logic [ADDR_W-1:0] r_last_idx;
    logic [ADDR_W-1:0] r_word_idx;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_halt;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_sync;
    logic              w_data_byte;
    logic [15:0]       w_count;
    logic [31:0]       w_word;
    logic              w_word_done;
    logic              w_last_word;

    assign w_accept    = rx_valid && rx_ready;
    assign w_sync      = (r_state == StIdle) && w_accept && (rx_data == SYNC_BYTE);
    assign w_data_byte = (r_state == StData) && w_accept;
    assign w_count     = {r_cnt_hi, rx_data};
    assign w_last_word = w_word_done && (r_word_idx == r_last_idx);

    loader_word_asm u_word_asm (
        .i_clk       (clk1),
        .i_rst       (reset),
        .i_byte      (rx_data),
        .i_strobe    (w_data_byte),
        .i_clear     (w_sync),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_chk;

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_chk <= '0;
        end else if (w_sync) begin
            r_chk <= '0;
        end else if (w_data_byte) begin
            r_chk <= r_chk ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_sync) w_state_next = StCntHi;
            end
            StCntHi: begin
                if (w_accept) w_state_next = StCntLo;
            end
            StCntLo: begin
                if (w_accept) begin
                    w_state_next = count_valid(w_count, ADDR_W) ? StData : StError;
                end
            end
            StData: begin
                if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_next = StChk;
`else
                    w_state_next = StStart;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StChk: begin
                if (w_accept) w_state_next = (rx_data == r_chk) ? StStart : StError;
            end
`endif
            StStart: w_state_next = StIdle;
            StError: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        rx_ready   = 1'b1;
        core_start = 1'b0;
        if (r_state == StStart) begin
            rx_ready   = 1'b0;
            core_start = 1'b1;
        end else if (r_state == StError) begin
            rx_ready   = 1'b0;
        end
    end

    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_cnt_hi   <= '0;
            r_last_idx <= '0;
            r_word_idx <= '0;
        end else begin
            if (r_state == StCntHi && w_accept) r_cnt_hi <= rx_data;
            if (r_state == StCntLo && w_accept) r_last_idx <= ADDR_W'(w_count - 16'd1);
            if (w_sync) begin
                r_word_idx <= '0;
            end else if (w_word_done) begin
                r_word_idx <= r_word_idx + ADDR_W'(1);
            end
        end
    end

    // Memory port is registered: the write appears the cycle after the 4th byte.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_word_done;
            if (w_word_done) begin
                r_mem_addr  <= r_word_idx;
                r_mem_wdata <= DATA_W'(w_word);
            end
        end
    end

    // Status flags change on entry to START/ERROR so they are visible during that cycle.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            r_halt <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_sync) begin
                r_halt <= 1'b1;
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end
            if (w_state_next == StStart) begin
                r_halt <= 1'b0;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_state_next == StError) begin
                r_busy <= 1'b0;
                r_err  <= 1'b1;
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign core_halt = r_halt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
